// File: rtl/mdsa_pkg.sv
// Shared definitions for the MDSA blocks: default geometry, index width helper
// and the unloader state encoding.
package mdsa_pkg;

  localparam int N  = 8;
  localparam int DW = 32;

  // Width of an index over n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IW = idx_w(N);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/mdsa_unloader_if.sv
// Element stream from the unloader to its consumer (valid/ready handshake
// plus element coordinates and end-of-matrix marker).
interface mdsa_unloader_if
  import mdsa_pkg::*;
#(
  parameter int N  = mdsa_pkg::N,
  parameter int DW = mdsa_pkg::DW,
  parameter int IW = idx_w(N)
);

  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_row;
  logic [IW-1:0] out_col;
  logic          out_last;

  modport master (
    output out_data, out_valid, out_row, out_col, out_last,
    input  out_ready
  );

  modport slave (
    input  out_data, out_valid, out_row, out_col, out_last,
    output out_ready
  );

endinterface

// File: rtl/mdsa_index_gen.sv
// Row/column sequencer for the unloader. Keeps a row counter and a position
// within the row; the emitted column is the position, mirrored on odd rows
// when snake order is selected. The counter saturates on the final element.
module mdsa_index_gen
  import mdsa_pkg::*;
#(
  parameter int N  = mdsa_pkg::N,
  parameter int IW = idx_w(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          advance,
  input  logic          snake,
  output logic [IW-1:0] row,
  output logic [IW-1:0] col,
  output logic          last
);

  localparam logic [IW-1:0] MAX = IW'(N - 1);

  logic [IW-1:0] row_q, row_d;
  logic [IW-1:0] pos_q, pos_d;

  // Next index: restart on clear, step once per transfer, hold at the end.
  always_comb begin
    row_d = row_q;
    pos_d = pos_q;
    if (clear) begin
      row_d = '0;
      pos_d = '0;
    end else if (advance && !last) begin
      if (pos_q == MAX) begin
        pos_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        pos_d = pos_q + 1'b1;
      end
    end
  end

  // Index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q <= '0;
      pos_q <= '0;
    end else begin
      row_q <= row_d;
      pos_q <= pos_d;
    end
  end

  // The last element is the end of the last row whatever the column order.
  assign last = (row_q == MAX) && (pos_q == MAX);
  assign row  = row_q;
  assign col  = (snake && row_q[0]) ? (MAX - pos_q) : pos_q;

endmodule

// File: rtl/mdsa_unloader.sv
// Streams a captured N x N matrix out one element per handshake, in row-major
// or snake order. Holds the FSM, the capture register and the element mux.
//
//   state  | meaning
//   IDLE   | waiting for cap; capture register loads on cap
//   STREAM | out_valid high, one element per out_valid & out_ready
//   DONE   | one-cycle done pulse after the final transfer
module mdsa_unloader
  import mdsa_pkg::*;
#(
  parameter int N  = mdsa_pkg::N,
  parameter int DW = mdsa_pkg::DW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cap,
  input  logic [N*N*DW-1:0]   matrix_in,
  input  logic                snake,
  output logic                busy,
  output logic                done,
  mdsa_unloader_if.master     out_if
);

  localparam int IW = idx_w(N);
  localparam int EW = idx_w(N * N);

  state_e              state_q, state_d;
  logic [N*N*DW-1:0]   mat_q, mat_d;
  logic                snake_q, snake_d;

  logic [IW-1:0]       row;
  logic [IW-1:0]       col;
  logic                last;
  logic                valid;
  logic                fire;
  logic [EW-1:0]       flat;
  logic [DW-1:0]       elem [N*N];

  assign valid = (state_q == STREAM);
  assign fire  = valid && out_if.out_ready;

  // Next state and capture; the matrix only loads from IDLE so a cap while
  // streaming (or in DONE) can never disturb the current stream.
  always_comb begin
    state_d = state_q;
    mat_d   = mat_q;
    snake_d = snake_q;
    unique case (state_q)
      IDLE: begin
        if (cap) begin
          state_d = STREAM;
          mat_d   = matrix_in;
          snake_d = snake;
        end
      end
      STREAM: begin
        if (fire && last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and capture registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mat_q   <= '0;
      snake_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mat_q   <= mat_d;
      snake_q <= snake_d;
    end
  end

  // Index counters rest at (0,0) outside STREAM so each stream starts clean.
  mdsa_index_gen #(
    .N  (N),
    .IW (IW)
  ) u_index_gen (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q != STREAM),
    .advance (fire),
    .snake   (snake_q),
    .row     (row),
    .col     (col),
    .last    (last)
  );

  // Split the capture register into addressable elements.
  always_comb begin
    for (int i = 0; i < N * N; i++) begin
      elem[i] = mat_q[i*DW +: DW];
    end
  end

  assign flat = EW'(row) * EW'(N) + EW'(col);

  assign out_if.out_valid = valid;
  assign out_if.out_data  = elem[flat];
  assign out_if.out_row   = row;
  assign out_if.out_col   = col;
  assign out_if.out_last  = valid && last;

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_mdsa_unloader.sv
// Directed bench for mdsa_unloader using the 0x100*r + c test matrix.
module tb_mdsa_unloader;
  import mdsa_pkg::*;

  localparam int MW = N * N * DW;

  logic          clk;
  logic          rst;
  logic          cap;
  logic          snake;
  logic [MW-1:0] matrix_in;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;

  mdsa_unloader_if u_if ();

  mdsa_unloader dut (
    .clk       (clk),
    .rst       (rst),
    .cap       (cap),
    .matrix_in (matrix_in),
    .snake     (snake),
    .busy      (busy),
    .done      (done),
    .out_if    (u_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [MW-1:0] mk(input logic [31:0] base);
    logic [MW-1:0] m;
    m = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        m[(r*N+c)*DW +: DW] = base + 32'h100 * r + c;
    return m;
  endfunction

  function automatic int exp_col(input int k, input bit snk);
    int r, p;
    r = k / N;
    p = k % N;
    return (snk && r[0]) ? (N - 1 - p) : p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input bit snk, input logic [31:0] base);
    matrix_in = mk(base);
    snake     = snk;
    cap       = 1'b1;
    chk("pre_cap_valid", u_if.out_valid, 1'b0);
    step();
    cap = 1'b0;
  endtask

  // Consume one full stream starting at element k0; compares every presented
  // element against the model and checks hold-stability during stalls.
  task automatic drain(input bit snk, input bit bp, input bit poke, input bit churn,
                       input logic [31:0] base, input int k0);
    int k, cyc, r, c;
    bit stalled;
    logic [DW-1:0] held;
    k = k0; cyc = 0; stalled = 0; held = '0;
    while (k < N * N && cyc < 1000) begin
      u_if.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (churn) begin
        matrix_in = mk(32'hF000_0000 + cyc);
        snake     = cyc[0];
      end
      if (poke && (k == 20 || k == N * N - 1)) begin
        matrix_in = mk(32'h000A_0000);
        cap       = 1'b1;
      end else begin
        cap = 1'b0;
      end
      r = k / N;
      c = exp_col(k, snk);
      chk("valid", u_if.out_valid, 1'b1);
      chk("busy_stream", busy, 1'b1);
      chk("data", u_if.out_data, base + 32'h100 * r + c);
      chk("row", u_if.out_row, r);
      chk("col", u_if.out_col, c);
      chk("last", u_if.out_last, (k == N * N - 1));
      if (stalled) chk("stall_hold", u_if.out_data, held);
      if (u_if.out_ready) begin
        k++;
        stalled = 0;
      end else begin
        stalled = 1;
        held    = u_if.out_data;
      end
      step();
      cyc++;
    end
    chk("xfer_count", k, N * N);
    if (!poke) cap = 1'b0;
    chk("done_pulse", done, 1'b1);
    chk("busy_done", busy, 1'b1);
    chk("valid_done", u_if.out_valid, 1'b0);
    step();
    cap = 1'b0;
    u_if.out_ready = 1'b1;
    chk("done_clear", done, 1'b0);
    chk("busy_idle", busy, 1'b0);
    chk("valid_idle", u_if.out_valid, 1'b0);
    step();
    step();
    chk("no_restart", u_if.out_valid, 1'b0);
    chk("no_restart_busy", busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    cap = 1'b0;
    snake = 1'b0;
    matrix_in = '0;
    u_if.out_ready = 1'b1;
    #1;
    chk("rst_valid", u_if.out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_data", u_if.out_data, 32'h0);
    chk("rst_last", u_if.out_last, 1'b0);
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("idle_valid", u_if.out_valid, 1'b0);
    chk("idle_busy", busy, 1'b0);

    // row-major burst, ready held high
    start(1'b0, 32'h0);
    drain(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0);

    // snake order
    start(1'b1, 32'h0);
    drain(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 0);

    // backpressure
    start(1'b0, 32'h0);
    drain(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 0);
    start(1'b1, 32'h0);
    drain(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 0);

    // caps during the stream and on the final transfer are ignored
    start(1'b0, 32'h0);
    drain(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 0);

    // inputs churn after capture
    start(1'b1, 32'h0);
    drain(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 0);

    // reset at element 30, then restart with a new matrix
    start(1'b0, 32'h0);
    for (int k = 0; k < 30; k++) begin
      u_if.out_ready = 1'b1;
      step();
    end
    chk("pre_rst_data", u_if.out_data, 32'h306);
    chk("pre_rst_valid", u_if.out_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", u_if.out_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_data", u_if.out_data, 32'h0);
    chk("mid_rst_row", u_if.out_row, 0);
    chk("mid_rst_col", u_if.out_col, 0);
    chk("mid_rst_last", u_if.out_last, 1'b0);
    step();
    chk("held_rst_valid", u_if.out_valid, 1'b0);
    rst = 1'b0;
    step();
    chk("post_rst_valid", u_if.out_valid, 1'b0);
    rst = 1'b1;
    step();
    // cap presented together with reset release must be taken at the next edge
    rst = 1'b0;
    start(1'b0, 32'h000A_0000);
    drain(1'b0, 1'b0, 1'b0, 1'b0, 32'h000A_0000, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
